// File: rtl/fix_div_seq.sv
// fix_div_seq: sequencer around the free-running fix_div sign-magnitude Qm.Q divider.
//   Takes operand pairs on a valid/ready input stream, runs one division and
//   presents the quotient on a valid/ready output stream. A completion watchdog
//   covers a divider that never finishes. An optional divide-by-zero bypass is
//   enabled by defining FIX_DIV_SEQ_DBZ_EN.
// Latency: out_valid rises N+Q+1 cycles after the accepting edge; with the
//   bypass active it rises 1 cycle after the accepting edge. One result per
//   N+Q+3 cycles when out_ready is held high.
// Backpressure: out_quotient/out_err are held while out_ready=0. in_ready stays
//   low until the result has been taken (one bubble per transaction) and while
//   the divider reports busy.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               operand stream handshake
//   in_dividend, in_divisor [N]     sign-magnitude operands
//   div_start                       one-cycle start pulse to fix_div
//   div_dividend, div_divisor [N]   registered operands to fix_div
//   div_quotient [N], div_complete  result and idle/done flag from fix_div
//   out_valid/out_ready             result stream handshake
//   out_quotient [N]                sign-magnitude result
//   out_err [2]                     {timeout, dbz}; 00 = normal result
module fix_div_seq #(
  parameter int N   = 16,
  parameter int Q   = 8,
  parameter int TMO = N + Q + 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_dividend,
  input  logic [N-1:0] in_divisor,
  output logic         div_start,
  output logic [N-1:0] div_dividend,
  output logic [N-1:0] div_divisor,
  input  logic [N-1:0] div_quotient,
  input  logic         div_complete,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_quotient,
  output logic [1:0]   out_err
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_dividend;
  logic [N-1:0]   r_divisor;
  logic [N-1:0]   r_quotient;
  logic [1:0]     r_err;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic           w_dbz;
  logic           w_waiting;
  logic           w_tmo;

  // The divider has no reset, so after our reset it may still be finishing
  // an old run; only hand it new work once it reports complete.
  assign in_ready  = (r_state == S_IDLE) & div_complete;
  assign w_accept  = in_valid & in_ready;
  assign w_waiting = (r_state == S_WAIT_LO) | (r_state == S_WAIT_HI);
  // Counter holds the number of completed wait cycles; the abort edge is the
  // TMO-th cycle spent waiting.
  assign w_tmo     = w_waiting & (r_cnt == CW'(TMO - 1));

`ifdef FIX_DIV_SEQ_DBZ_EN
  assign w_dbz = (in_divisor[N-2:0] == '0);
`else
  assign w_dbz = 1'b0;
`endif

  assign div_start    = (r_state == S_START);
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign out_valid    = (r_state == S_OUT);
  assign out_quotient = r_quotient;
  assign out_err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_dbz ? S_OUT : S_START;
        end
      end
      S_START: begin
        w_next = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (w_tmo) begin
          w_next = S_OUT;
        end else if (!div_complete) begin
          w_next = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        // Timeout wins over a completion arriving on the same edge.
        if (w_tmo || div_complete) begin
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quotient <= '0;
      r_err      <= 2'b00;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_dividend <= in_dividend;
        r_divisor  <= in_divisor;
        r_cnt      <= '0;
        if (w_dbz) begin
          // Saturated magnitude carrying the quotient's sign.
          r_quotient <= {in_dividend[N-1] ^ in_divisor[N-1], {(N-1){1'b1}}};
          r_err      <= 2'b01;
        end
      end else if (w_waiting) begin
        if (w_tmo) begin
          r_quotient <= '0;
          r_err      <= 2'b10;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if ((r_state == S_WAIT_HI) && div_complete) begin
            r_quotient <= div_quotient;
            r_err      <= 2'b00;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fix_div_seq.sv
module tb_fix_div_seq;

  localparam int N   = 16;
  localparam int Q   = 8;
  localparam int TMO = N + Q + 4;
  localparam int LAT = N + Q + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_dividend;
  logic [N-1:0] in_divisor;
  logic         div_start;
  logic [N-1:0] div_dividend;
  logic [N-1:0] div_divisor;
  logic [N-1:0] div_quotient;
  logic         div_complete;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_quotient;
  logic [1:0]   out_err;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  fix_div_seq #(.N(N), .Q(Q), .TMO(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_complete (div_complete),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_err      (out_err)
  );

  // Stand-in for fix_div: no reset, busy for stub_delay+1 cycles after a
  // start, then raises complete with the truncated sign-magnitude quotient.
  logic         m_complete = 1'b0;
  logic [N-1:0] m_q = '0;
  int           m_cnt = 10;
  int           stub_delay = N + Q - 1;

  function automatic logic [N-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] num;
    logic [2*N-1:0] den;
    logic [N-1:0]   mag;
    mag = {1'b0, {(N-1){1'b1}}};
    den = {{(N+1){1'b0}}, b[N-2:0]};
    if (den != '0) begin
      num = {{(N+1){1'b0}}, a[N-2:0]} << Q;
      num = num / den;
      mag = {1'b0, num[N-2:0]};
    end
    return {a[N-1] ^ b[N-1], mag[N-2:0]};
  endfunction

  always @(posedge clk) begin
    if (div_start) begin
      m_complete <= 1'b0;
      m_cnt      <= stub_delay;
      m_q        <= ref_div(div_dividend, div_divisor);
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt      <= 0;
      m_complete <= 1'b1;
    end
  end

  assign div_complete = m_complete;
  assign div_quotient = m_q;

  always @(posedge clk) begin
    if (div_start) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operand pair, wait for its accept and then for out_valid.
  // lat counts edges from the accepting edge to the edge raising out_valid.
  task automatic run_op(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                        output logic [N-1:0] q, output logic [1:0] err,
                        output int lat, output int nstart);
    int s0;
    int guard;
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = dvd;
    in_divisor  = dvs;
    guard = 0;
    while (!in_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready never rose for 0x%0h/0x%0h", dvd, dvs);
    end
    s0 = start_cnt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: out_valid never rose for 0x%0h/0x%0h", dvd, dvs);
    end
    q      = out_quotient;
    err    = out_err;
    nstart = start_cnt - s0;
  endtask

  typedef struct {
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic [N-1:0] q;
    logic [1:0]   err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [N-1:0] q;
    logic [N-1:0] q0;
    logic [1:0]   err;
    int           lat;
    int           ns;
    int           bad;
    int           s0;

    vecs[0] = '{16'h0300, 16'h0200, 16'h0180, 2'b00};
    vecs[1] = '{16'h8300, 16'h0200, 16'h8180, 2'b00};
    vecs[2] = '{16'h8300, 16'h8200, 16'h0180, 2'b00};
    vecs[3] = '{16'h0100, 16'h0300, 16'h0055, 2'b00};
    vecs[4] = '{16'h0080, 16'h0200, 16'h0040, 2'b00};
    vecs[5] = '{16'h0A00, 16'h0400, 16'h0280, 2'b00};
    vecs[6] = '{16'h8001, 16'h0100, 16'h8001, 2'b00};
    vecs[7] = '{16'h0700, 16'h0300, 16'h0255, 2'b00};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b1;
    #1;
    check("rst_in_ready",   32'(in_ready),     32'h0);
    check("rst_out_valid",  32'(out_valid),    32'h0);
    check("rst_div_start",  32'(div_start),    32'h0);
    check("rst_quotient",   32'(out_quotient), 32'h0);
    check("rst_err",        32'(out_err),      32'h0);
    check("rst_dividend",   32'(div_dividend), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Divider still busy from power-up: nothing may be accepted yet.
    check("boot_gate_in_ready", 32'(in_ready), 32'h0);

    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, q, err, lat, ns);
      check($sformatf("vec%0d_quotient", i), 32'(q),   32'(vecs[i].q));
      check($sformatf("vec%0d_err", i),      32'(err), 32'(vecs[i].err));
      check($sformatf("vec%0d_latency", i),  32'(lat), 32'(LAT));
      check($sformatf("vec%0d_div_dividend", i), 32'(div_dividend), 32'(vecs[i].dvd));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_drop", i), 32'(out_valid), 32'h0);
    end

    // Backpressure: result held, no new accept while out_ready is low.
    out_ready = 1'b0;
    run_op(16'h0A00, 16'h0400, q, err, lat, ns);
    check("bp_quotient", 32'(q), 32'h0280);
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = 16'h0300;
    in_divisor  = 16'h0200;
    q0  = out_quotient;
    s0  = start_cnt;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (!out_valid || out_quotient !== q0 || out_err !== 2'b00 || in_ready) bad++;
    end
    check("bp_hold_violations", 32'(bad), 32'h0);
    check("bp_no_new_start", 32'(start_cnt - s0), 32'h0);
    @(negedge clk);
    in_valid  = 1'b0;
    check("bp_in_ready_at_out", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_released", 32'(out_valid), 32'h0);
    check("bp_ready_after", 32'(in_ready), 32'h1);

    // Watchdog: divider stays busy far beyond the limit.
    stub_delay = 200;
    run_op(16'h0300, 16'h0200, q, err, lat, ns);
    check("wd_quotient", 32'(q),   32'h0);
    check("wd_err",      32'(err), 32'h2);
    check("wd_latency",  32'(lat), 32'(TMO + 1));
    // Completion landing on the timeout edge: timeout wins.
    stub_delay = TMO - 1;
    run_op(16'h0300, 16'h0200, q, err, lat, ns);
    check("wd_tie_quotient", 32'(q),   32'h0);
    check("wd_tie_err",      32'(err), 32'h2);
    check("wd_tie_latency",  32'(lat), 32'(TMO + 1));
    // Completion one cycle before the limit still yields the real result.
    stub_delay = TMO - 2;
    run_op(16'h0300, 16'h0200, q, err, lat, ns);
    check("wd_edge_quotient", 32'(q),   32'h0180);
    check("wd_edge_err",      32'(err), 32'h0);
    check("wd_edge_latency",  32'(lat), 32'(TMO));
    stub_delay = N + Q - 1;

    // Reset while waiting for the divider.
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = 16'h0700;
    in_divisor  = 16'h0300;
    bad = 0;
    while (!in_ready && bad < 400) begin
      @(negedge clk);
      bad++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid),    32'h0);
    check("mid_rst_quotient",  32'(out_quotient), 32'h0);
    check("mid_rst_dividend",  32'(div_dividend), 32'h0);
    check("mid_rst_in_ready",  32'(in_ready),     32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_gate", 32'(in_ready), 32'h0);
    run_op(16'h8300, 16'h8200, q, err, lat, ns);
    check("post_rst_quotient", 32'(q),   32'h0180);
    check("post_rst_latency",  32'(lat), 32'(LAT));
    @(posedge clk);
    #1;

    // Zero divisor.
    run_op(16'h8400, 16'h8000, q, err, lat, ns);
`ifdef FIX_DIV_SEQ_DBZ_EN
    check("dbz_quotient", 32'(q),   32'h7FFF);
    check("dbz_err",      32'(err), 32'h1);
    check("dbz_fast",     32'(lat <= 2), 32'h1);
    check("dbz_no_start", 32'(ns),  32'h0);
`else
    check("zdiv_err",     32'(err), 32'h0);
    check("zdiv_start",   32'(ns),  32'h1);
    check("zdiv_latency", 32'(lat), 32'(LAT));
`endif
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
